regfile_mp: RTL and testbench



---
 rtl/regfile_pkg.sv | 22 ++
 rtl/regfile_read_port.sv | 58 +++++
 rtl/regfile_mp.sv | 102 ++++++++++
 tb/tb_regfile_mp.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// regfile_pkg : shared state type, default sizes and address helper
//               for the regfile_mp register file.          Rev 1.0
// ------------------------------------------------------------------
package regfile_pkg;

  typedef enum logic [1:0] {
    RF_CLEAR = 2'b00,
    RF_READY = 2'b01
  } rf_state_t;

  localparam int c_DEF_XLEN  = 64;
  localparam int c_DEF_NREGS = 32;
  localparam int c_DEF_NRD   = 2;

  function automatic int rf_aw(input int nregs);
    return $clog2(nregs);
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_read_port.sv
`default_nettype none
// ------------------------------------------------------------------
// regfile_read_port : one registered read port with x0 check and the
//                     REGFILE_BYPASS_EN write-through mux.   Rev 1.0
// ------------------------------------------------------------------
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int XLEN  = c_DEF_XLEN,
  parameter int NREGS = c_DEF_NREGS,
  localparam int AW   = rf_aw(NREGS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_ready,
  input  logic [AW-1:0]           i_addr,
  input  logic [NREGS*XLEN-1:0]   i_regs,
`ifdef REGFILE_BYPASS_EN
  input  logic                    i_we,
  input  logic [AW-1:0]           i_wa,
  input  logic [XLEN-1:0]         i_wdata,
`endif
  output logic [XLEN-1:0]         o_data
);

  logic [XLEN-1:0] w_regs [NREGS];
  logic [XLEN-1:0] w_data;
  logic [XLEN-1:0] r_data;

  for (genvar j = 0; j < NREGS; j++) begin : g_unpack
    assign w_regs[j] = i_regs[j*XLEN +: XLEN];
  end

  always_comb begin
    w_data = '0;
    if (i_addr != '0) begin
      w_data = w_regs[i_addr];
    end
`ifdef REGFILE_BYPASS_EN
    // Nonzero match implies i_addr is nonzero, so x0 can never be forwarded.
    if (i_we && (i_wa != '0) && (i_wa == i_addr)) begin
      w_data = i_wdata;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst || !i_ready) begin
      r_data <= '0;
    end else begin
      r_data <= w_data;
    end
  end

  assign o_data = r_data;

endmodule
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ------------------------------------------------------------------
// regfile_mp : multi-read-port register file with reset clear sweep;
//              REGFILE_BYPASS_EN enables write-to-read bypass. Rev 1.0
// ------------------------------------------------------------------
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN  = c_DEF_XLEN,
  parameter int NREGS = c_DEF_NREGS,
  parameter int NRD   = c_DEF_NRD,
  localparam int AW   = rf_aw(NREGS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NRD*AW-1:0]     rs,
  input  logic [AW-1:0]         rd,
  input  logic [XLEN-1:0]       WriteData,
  input  logic                  RegWrite,
  output logic [NRD*XLEN-1:0]   ReadData,
  output logic                  busy
);

  localparam logic [AW-1:0] c_LAST = AW'(NREGS - 1);

  rf_state_t               r_state;
  rf_state_t               w_state_nxt;
  logic [AW-1:0]           r_cnt;
  logic [AW-1:0]           w_cnt_nxt;
  logic [XLEN-1:0]         r_regs [NREGS];
  logic [NREGS*XLEN-1:0]   w_regs_flat;
  logic                    w_ready;
  logic                    w_clear;

  assign w_ready = (r_state == RF_READY);
  assign w_clear = (r_state == RF_CLEAR);
  assign busy    = ~w_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= RF_CLEAR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      RF_CLEAR: begin
        w_cnt_nxt = r_cnt + AW'(1);
        if (r_cnt == c_LAST) begin
          w_state_nxt = RF_READY;
        end
      end
      RF_READY: w_state_nxt = RF_READY;
      default: begin
        w_state_nxt = RF_CLEAR;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // The array has no reset: the sweep is what clears it, one entry per cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (w_clear) begin
        r_regs[r_cnt] <= '0;
      end else if (w_ready && RegWrite && (rd != '0)) begin
        r_regs[rd] <= WriteData;
      end
    end
  end

  for (genvar j = 0; j < NREGS; j++) begin : g_flat
    assign w_regs_flat[j*XLEN +: XLEN] = r_regs[j];
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rdport
    regfile_read_port #(
      .XLEN  (XLEN),
      .NREGS (NREGS)
    ) u_port (
      .clk     (clk),
      .rst     (reset),
      .i_ready (w_ready),
      .i_addr  (rs[i*AW +: AW]),
      .i_regs  (w_regs_flat),
`ifdef REGFILE_BYPASS_EN
      .i_we    (RegWrite),
      .i_wa    (rd),
      .i_wdata (WriteData),
`endif
      .o_data  (ReadData[i*XLEN +: XLEN])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_regfile_mp : vector table + scoreboard bench for regfile_mp
//                 (expectations follow REGFILE_BYPASS_EN).   Rev 1.0
// ------------------------------------------------------------------
module tb_regfile_mp;

`ifdef REGFILE_BYPASS_EN
  localparam bit c_BYP = 1'b1;
`else
  localparam bit c_BYP = 1'b0;
`endif

  localparam logic [63:0] c_DEAD = 64'hDEAD_BEEF_0000_0001;
  localparam logic [63:0] c_ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] c_PAT  = 64'hC3C3_5A5A_0F0F_A5A5;

  logic         clk;
  logic         reset;
  logic [9:0]   rs;
  logic [4:0]   rd;
  logic [63:0]  WriteData;
  logic         RegWrite;
  logic [127:0] ReadData;
  logic         busy;

  regfile_mp dut (
    .clk       (clk),
    .reset     (reset),
    .rs        (rs),
    .rd        (rd),
    .WriteData (WriteData),
    .RegWrite  (RegWrite),
    .ReadData  (ReadData),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [63:0] wd;
    logic [4:0]  a0;
    logic [4:0]  a1;
    logic [63:0] e0;
    logic [63:0] e1;
  } vec_t;

  typedef struct {
    string        tag;
    logic [127:0] exp;
  } sb_t;

  vec_t tbl [12];
  sb_t  sb [$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic void check(input string name, input logic [127:0] act,
                                input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endfunction

  // Pops the oldest expectation once the DUT has had its posedge.
  task automatic retire();
    sb_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_underflow: got empty queue, expected an entry");
    end else begin
      e = sb.pop_front();
      check(e.tag, ReadData, e.exp);
    end
  endtask

  // Called at a negedge: drive one cycle of inputs, queue the result for next cycle.
  task automatic issue(input logic we, input logic [4:0] wa, input logic [63:0] wd,
                       input logic [4:0] a0, input logic [4:0] a1,
                       input logic [63:0] e0, input logic [63:0] e1, input string tag);
    sb_t e;
    RegWrite  = we;
    rd        = wa;
    WriteData = wd;
    rs        = {a1, a0};
    e.tag = tag;
    e.exp = {e1, e0};
    sb.push_back(e);
    @(negedge clk);
    RegWrite = 1'b0;
    retire();
  endtask

  // Called at the negedge where reset has just been dropped; counts busy cycles.
  task automatic sweep_count(input int wr_at, input logic [4:0] wr_reg, input int rst_at,
                             output int n_busy, output bit rd_nz);
    n_busy = 0;
    rd_nz  = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (!busy) break;
      n_busy++;
      if (ReadData != '0) rd_nz = 1'b1;
      RegWrite  = (c == wr_at);
      rd        = wr_reg;
      WriteData = 64'hA;
      rs        = {wr_reg, wr_reg};
      reset     = (c == rst_at);
      @(negedge clk);
    end
    RegWrite = 1'b0;
    reset    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    bit nz;

    tbl[0]  = '{1'b1, 5'd5,  c_DEAD,     5'd0,  5'd0,  64'd0, 64'd0};
    tbl[1]  = '{1'b0, 5'd0,  64'd0,      5'd5,  5'd5,  c_DEAD, c_DEAD};
    tbl[2]  = '{1'b1, 5'd0,  c_ONES,     5'd5,  5'd0,  c_DEAD, 64'd0};
    tbl[3]  = '{1'b0, 5'd0,  64'd0,      5'd0,  5'd0,  64'd0, 64'd0};
    tbl[4]  = '{1'b1, 5'd7,  64'h55,     5'd1,  5'd2,  64'd0, 64'd0};
    tbl[5]  = '{1'b1, 5'd7,  64'h1234,   5'd7,  5'd5,  c_BYP ? 64'h1234 : 64'h55, c_DEAD};
    tbl[6]  = '{1'b0, 5'd0,  64'd0,      5'd7,  5'd7,  64'h1234, 64'h1234};
    tbl[7]  = '{1'b1, 5'd31, c_PAT,      5'd31, 5'd0,  c_BYP ? c_PAT : 64'd0, 64'd0};
    tbl[8]  = '{1'b0, 5'd0,  64'd0,      5'd31, 5'd30, c_PAT, 64'd0};
    tbl[9]  = '{1'b1, 5'd0,  c_ONES,     5'd0,  5'd7,  64'd0, 64'h1234};
    tbl[10] = '{1'b1, 5'd30, 64'hABC,    5'd31, 5'd30, c_PAT, c_BYP ? 64'hABC : 64'd0};
    tbl[11] = '{1'b0, 5'd0,  64'd0,      5'd30, 5'd5,  64'hABC, c_DEAD};

    reset = 1'b1; RegWrite = 1'b0; rd = '0; WriteData = '0; rs = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_readdata", ReadData, 128'd0);
    check("reset_busy", 128'(busy), 128'd1);
    reset = 1'b0;

    // First sweep; x9 written at sweep cycle 10 must be dropped.
    sweep_count(10, 5'd9, -1, nb, nz);
    check("sweep1_busy_cycles", 128'(nb), 128'd32);
    check("sweep1_readdata_zero", 128'(nz), 128'd0);
    for (int i = 1; i < 32; i++) begin
      issue(1'b0, 5'd0, 64'd0, 5'(i), 5'(32 - i), 64'd0, 64'd0,
            $sformatf("post_sweep_read_x%0d", i));
    end

    // Second sweep, restarted by a 1-cycle reset at sweep cycle 20.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    sweep_count(5, 5'd3, 20, nb, nz);
    check("sweep2_busy_cycles", 128'(nb), 128'd53);
    check("sweep2_readdata_zero", 128'(nz), 128'd0);
    issue(1'b0, 5'd0, 64'd0, 5'd3, 5'd9, 64'd0, 64'd0, "sweep2_write_ignored");

    for (int k = 0; k < 12; k++) begin
      issue(tbl[k].we, tbl[k].wa, tbl[k].wd, tbl[k].a0, tbl[k].a1,
            tbl[k].e0, tbl[k].e1, $sformatf("vec%0d", k));
    end

    // A fresh reset must wipe previously written registers.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    sweep_count(-1, 5'd0, -1, nb, nz);
    check("sweep3_busy_cycles", 128'(nb), 128'd32);
    issue(1'b0, 5'd0, 64'd0, 5'd5, 5'd7, 64'd0, 64'd0, "sweep3_cleared_x5_x7");
    issue(1'b0, 5'd0, 64'd0, 5'd30, 5'd31, 64'd0, 64'd0, "sweep3_cleared_x30_x31");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
